surf_lbus_target: RTL

SURF_LBUS_TARGET -- requirements
Module: surf_lbus_target

---
 rtl/surf_lbus_target.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/surf_lbus_target.sv
// surf_lbus_target: local-bus target serving housekeeping (HK), LAB readout and
// control/status register spaces. Space and start address are decoded at the
// address strobe. Every cycle spent in WR or RD_BEAT accepts one beat.
module surf_lbus_target #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_LABS  = 4,
  parameter int unsigned LAB_AW    = 11,
  parameter int unsigned HK_AW     = 7,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned LSEL_W   = $clog2(NUM_LABS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ads_n_i,
  input  logic                     wnr_i,
  input  logic                     cs2_n_i,
  input  logic                     cs3_n_i,
  input  logic                     blast_n_i,
  input  logic [5:0]               la_i,
  input  logic [DATA_W-1:0]        ld_i,
  output logic [DATA_W-1:0]        ld_o,
  output logic                     ld_oe_o,
  output logic                     ready_n_o,
  output logic                     bterm_n_o,
  input  logic [DATA_W-1:0]        lab_dat_i,
  output logic [LSEL_W+LAB_AW-1:0] lab_addr_o,
  input  logic [DATA_W-1:0]        hk_dat_i,
  output logic [HK_AW-1:0]         hk_addr_o,
  output logic                     hk_wr_o,
  output logic                     hk_rd_o,
  input  logic                     evt_empty_i,
  input  logic [LSEL_W-1:0]        evt_sel_i,
  input  logic [31:0]              evt_id_i,
  output logic                     evt_rd_o,
  output logic                     clr_all_o,
  output logic [31:0]              mask_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [31:0] IDENT   = 32'h5355_5246;  // "SURF"
  localparam logic [31:0] VERSION = 32'h0001_0000;

  typedef enum logic [1:0] {StIdle, StWr, StRdWait, StRdBeat} state_e;
  typedef enum logic [1:0] {SpReg, SpHk, SpLab} space_e;

  state_e              state_q, state_d;
  space_e              space_q, space_d;
  logic [2:0]          reg_addr_q, reg_addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HK_AW-1:0]    hk_ptr_q, hk_ptr_d;
  logic [LAB_AW-1:0]   lab_ptr_q, lab_ptr_d;
  logic [31:0]         mask_q, mask_d;
  logic                busy_q, busy_d;
  logic                clr_q, clr_d;
  logic                pop_q, pop_d;

  logic                beat;
  logic                last_beat;
  logic                reg_wr;
  logic [31:0]         wdata;
  logic [31:0]         reg_rdata;
  logic                unused_la;

  assign unused_la = ^la_i[5:3];

  // Beat qualification shared by the FSM, pointers and handshake outputs.
  always_comb begin
    beat      = (state_q == StWr) || (state_q == StRdBeat);
    last_beat = beat && (cnt_q == LAST_CNT);
    reg_wr    = (state_q == StWr) && (space_q == SpReg);
    wdata     = 32'(ld_i);
  end

  // Burst FSM: decode at the strobe, then one beat per cycle until blast or forced bterm.
  always_comb begin
    state_d    = state_q;
    space_d    = space_q;
    reg_addr_d = reg_addr_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (!ads_n_i) begin
          state_d    = wnr_i ? StWr : StRdWait;
          space_d    = !cs2_n_i ? SpHk : (!cs3_n_i ? SpLab : SpReg);
          reg_addr_d = la_i[2:0];
          cnt_d      = '0;
        end
      end
      StRdWait: state_d = StRdBeat;
      StWr, StRdBeat: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (space_q == SpReg) reg_addr_d = reg_addr_q + 3'd1;
        if (!blast_n_i || last_beat) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pointer and register updates; priority is global clear, then event pop, then writes.
  always_comb begin
    hk_ptr_d  = hk_ptr_q;
    lab_ptr_d = lab_ptr_q;
    mask_d    = mask_q;
    busy_d    = busy_q;
    clr_d     = 1'b0;
    pop_d     = 1'b0;
    if (beat && (space_q == SpHk))  hk_ptr_d  = hk_ptr_q + HK_AW'(1);
    if (beat && (space_q == SpLab)) lab_ptr_d = lab_ptr_q + LAB_AW'(1);
    if (reg_wr) begin
      unique case (reg_addr_q)
        3'd2: hk_ptr_d  = wdata[HK_AW-1:0];
        3'd3: lab_ptr_d = wdata[LAB_AW-1:0];
        3'd6: begin
          busy_d = wdata[31];
          clr_d  = wdata[0];
          pop_d  = wdata[1];
        end
        3'd7: mask_d = wdata;
        default: ;
      endcase
    end
    if (evt_rd_o) lab_ptr_d = '0;
    if (clr_q) begin
      hk_ptr_d  = '0;
      lab_ptr_d = '0;
      mask_d    = '0;
      busy_d    = 1'b0;
    end
  end

  // Register-space read mux.
  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr_q)
      3'd0: reg_rdata = IDENT;
      3'd1: reg_rdata = VERSION;
      3'd2: reg_rdata = 32'(hk_ptr_q);
      3'd3: reg_rdata = 32'(lab_ptr_q);
      3'd4: reg_rdata = {27'b0, evt_empty_i, 3'(evt_sel_i), ~evt_empty_i};
      3'd5: reg_rdata = evt_id_i;
      3'd6: reg_rdata = {busy_q, 31'b0};
      3'd7: reg_rdata = mask_q;
      default: reg_rdata = '0;
    endcase
  end

  // Bus and side-port outputs. RAM addresses look one beat ahead so the
  // 1-cycle-latency data lines up with each read beat; HK writes use the current pointer.
  always_comb begin
    ld_oe_o   = (state_q == StRdWait) || (state_q == StRdBeat);
    ready_n_o = ~beat;
    bterm_n_o = ~last_beat;
    hk_wr_o   = (state_q == StWr) && (space_q == SpHk);
    hk_rd_o   = (state_q == StRdBeat) && (space_q == SpHk);
    evt_rd_o  = pop_q & ~evt_empty_i;
    clr_all_o = clr_q;
    mask_o    = mask_q;
    hk_addr_o = (state_q == StWr) ? hk_ptr_q : hk_ptr_d;
    lab_addr_o = {evt_sel_i, lab_ptr_d};
    ld_o      = '0;
    if (ld_oe_o) begin
      unique case (space_q)
        SpHk:    ld_o = hk_dat_i;
        SpLab:   ld_o = lab_dat_i;
        default: ld_o = DATA_W'(reg_rdata);
      endcase
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      space_q    <= SpReg;
      reg_addr_q <= '0;
      cnt_q      <= '0;
      hk_ptr_q   <= '0;
      lab_ptr_q  <= '0;
      mask_q     <= '0;
      busy_q     <= 1'b0;
      clr_q      <= 1'b0;
      pop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      space_q    <= space_d;
      reg_addr_q <= reg_addr_d;
      cnt_q      <= cnt_d;
      hk_ptr_q   <= hk_ptr_d;
      lab_ptr_q  <= lab_ptr_d;
      mask_q     <= mask_d;
      busy_q     <= busy_d;
      clr_q      <= clr_d;
      pop_q      <= pop_d;
    end
  end

endmodule
